sattn_mmio_host: RTL and testbench

- MMIO initiator for the sparse-attention accelerator register file. It drives the host side of the same bus that the accelerator responds on.
- Accepts one command descriptor per handshake and programs the 12 descriptor registers, then streams index entries into the index RAM and issues the CMD write.
- Polls status until done or timeout, reads back the command-specific checksum, and returns it on a response handshake.
- Used by the SoC-side sequencer and as the reusable bus driver in the accelerator testbench.

---
 rtl/sattn_mmio_host_if.sv | 51 +++++
 rtl/sattn_mmio_host.sv | 228 ++++++++++++++++++++++
 tb/tb_sattn_mmio_host.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sattn_mmio_host_if.sv
// Descriptor, index, MMIO and response channels of sattn_mmio_host.
// The perf-counter response fields exist only when SATTN_HOST_PERF_EN is defined.
interface sattn_mmio_host_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
);
    logic                  desc_valid;
    logic                  desc_ready;
    logic [383:0]          desc_bases;
    logic [191:0]          desc_dims;
    logic [7:0]            desc_cmd;
    logic [15:0]           desc_idx_cnt;
    logic                  idx_valid;
    logic                  idx_ready;
    logic [15:0]           idx_data;
    logic                  mmio_wen;
    logic                  mmio_ren;
    logic [ADDR_WIDTH-1:0] mmio_addr;
    logic [DATA_WIDTH-1:0] mmio_wdata;
    logic [DATA_WIDTH-1:0] mmio_rdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [63:0]           rsp_sum;
    logic                  rsp_err;
    logic [31:0]           rsp_polls;
`ifdef SATTN_HOST_PERF_EN
    logic [63:0]           rsp_gcyc;
    logic [63:0]           rsp_mcyc;
    logic [63:0]           rsp_dma;
`endif

    modport master (
        input  desc_valid, desc_bases, desc_dims, desc_cmd, desc_idx_cnt,
        input  idx_valid, idx_data, mmio_rdata, rsp_ready,
        output desc_ready, idx_ready, mmio_wen, mmio_ren, mmio_addr, mmio_wdata,
        output rsp_valid, rsp_sum, rsp_err, rsp_polls
`ifdef SATTN_HOST_PERF_EN
        , output rsp_gcyc, rsp_mcyc, rsp_dma
`endif
    );

    modport slave (
        output desc_valid, desc_bases, desc_dims, desc_cmd, desc_idx_cnt,
        output idx_valid, idx_data, mmio_rdata, rsp_ready,
        input  desc_ready, idx_ready, mmio_wen, mmio_ren, mmio_addr, mmio_wdata,
        input  rsp_valid, rsp_sum, rsp_err, rsp_polls
`ifdef SATTN_HOST_PERF_EN
        , input rsp_gcyc, rsp_mcyc, rsp_dma
`endif
    );
endinterface

// File: rtl/sattn_mmio_host.sv
// MMIO initiator: programs the sparse-attention register file, uploads indices, polls DONE, returns the checksum.
// Define SATTN_HOST_PERF_EN to also read back the three perf counters after the checksum.
module sattn_mmio_host #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 64,
    parameter int POLL_TIMEOUT = 65535
) (
    input logic               clk,
    input logic               rst,
    sattn_mmio_host_if.master bus
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WR_REGS = 4'd1;
    localparam logic [3:0] S_WR_IDX  = 4'd2;
    localparam logic [3:0] S_WR_CMD  = 4'd3;
    localparam logic [3:0] S_POLL    = 4'd4;
    localparam logic [3:0] S_SETTLE  = 4'd5;
    localparam logic [3:0] S_RD_SUM  = 4'd6;
    localparam logic [3:0] S_RESP    = 4'd7;
`ifdef SATTN_HOST_PERF_EN
    localparam logic [3:0] S_PERF    = 4'd8;
    localparam logic [3:0] S_TAIL    = S_PERF;
`else
    localparam logic [3:0] S_TAIL    = S_RESP;
`endif

    logic [3:0]   state;
    logic [383:0] bases_q;
    logic [191:0] dims_q;
    logic [7:0]   cmd_q;
    logic [15:0]  cnt_q;
    logic [3:0]   reg_idx;
    logic [15:0]  idx_k;
    logic         idx_phase_b;
    logic [63:0]  sum_q;
    logic         err_q;
    logic [31:0]  polls_q;
    logic [31:0]  polls_next;
    logic [63:0]  reg_wdata;
    logic         sum_rd;
    logic [7:0]   sum_addr;
    logic         bus_wen;
    logic         bus_ren;
    logic [7:0]   bus_addr;
    logic [63:0]  bus_wdata;
`ifdef SATTN_HOST_PERF_EN
    logic [1:0]   perf_idx;
    logic [63:0]  gcyc_q;
    logic [63:0]  mcyc_q;
    logic [63:0]  dma_q;
`endif

    assign polls_next = (polls_q == 32'hFFFF_FFFF) ? polls_q : polls_q + 32'd1;

    // Registers 0..5 are the 64-bit bases, 6..11 the zero-extended 32-bit dimensions.
    always_comb begin
        reg_wdata = 64'h0;
        for (int i = 0; i < 6; i++) begin
            if (reg_idx == 4'(i))     reg_wdata = bases_q[64*i +: 64];
            if (reg_idx == 4'(i + 6)) reg_wdata = {32'h0, dims_q[32*i +: 32]};
        end
    end

    always_comb begin
        sum_rd   = 1'b1;
        sum_addr = 8'h00;
        case (cmd_q)
            8'h14:   sum_addr = 8'h68;
            8'h15:   sum_addr = 8'h80;
            8'h16:   sum_addr = 8'h88;
            default: sum_rd   = 1'b0;
        endcase
    end

    always_comb begin
        bus_wen   = 1'b0;
        bus_ren   = 1'b0;
        bus_addr  = 8'h00;
        bus_wdata = 64'h0;
        case (state)
            S_WR_REGS: begin
                bus_wen   = 1'b1;
                bus_addr  = {1'b0, reg_idx, 3'b000};
                bus_wdata = reg_wdata;
            end
            S_WR_IDX: begin
                if (!idx_phase_b) begin
                    bus_wen   = 1'b1;
                    bus_addr  = 8'h70;
                    bus_wdata = {48'h0, idx_k};
                end else if (bus.idx_valid) begin
                    bus_wen   = 1'b1;
                    bus_addr  = 8'h78;
                    bus_wdata = {48'h0, bus.idx_data};
                end
            end
            S_WR_CMD: begin
                bus_wen   = 1'b1;
                bus_addr  = 8'h60;
                bus_wdata = {56'h0, cmd_q};
            end
            S_POLL: begin
                bus_ren  = 1'b1;
                bus_addr = 8'h60;
            end
            S_RD_SUM: begin
                bus_ren  = sum_rd;
                bus_addr = sum_rd ? sum_addr : 8'h00;
            end
`ifdef SATTN_HOST_PERF_EN
            S_PERF: begin
                bus_ren  = 1'b1;
                bus_addr = 8'h90 + {3'b000, perf_idx, 3'b000};
            end
`endif
            default: ;
        endcase
    end

    // Sequencer; response fields are cleared on accept so a NOP returns zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bases_q     <= '0;
            dims_q      <= '0;
            cmd_q       <= '0;
            cnt_q       <= '0;
            reg_idx     <= '0;
            idx_k       <= '0;
            idx_phase_b <= 1'b0;
            sum_q       <= '0;
            err_q       <= 1'b0;
            polls_q     <= '0;
`ifdef SATTN_HOST_PERF_EN
            perf_idx    <= '0;
            gcyc_q      <= '0;
            mcyc_q      <= '0;
            dma_q       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.desc_valid) begin
                        bases_q     <= bus.desc_bases;
                        dims_q      <= bus.desc_dims;
                        cmd_q       <= bus.desc_cmd;
                        cnt_q       <= bus.desc_idx_cnt;
                        reg_idx     <= '0;
                        idx_k       <= '0;
                        idx_phase_b <= 1'b0;
                        sum_q       <= '0;
                        err_q       <= 1'b0;
                        polls_q     <= '0;
`ifdef SATTN_HOST_PERF_EN
                        perf_idx    <= '0;
                        gcyc_q      <= '0;
                        mcyc_q      <= '0;
                        dma_q       <= '0;
`endif
                        state       <= S_WR_REGS;
                    end
                end
                S_WR_REGS: begin
                    reg_idx <= reg_idx + 4'd1;
                    if (reg_idx == 4'd11) begin
                        if (cnt_q != 16'd0)      state <= S_WR_IDX;
                        else if (cmd_q == 8'h00) state <= S_RESP;
                        else                     state <= S_WR_CMD;
                    end
                end
                S_WR_IDX: begin
                    if (!idx_phase_b) begin
                        idx_phase_b <= 1'b1;
                    end else if (bus.idx_valid) begin
                        idx_phase_b <= 1'b0;
                        idx_k       <= idx_k + 16'd1;
                        if (idx_k == cnt_q - 16'd1)
                            state <= (cmd_q == 8'h00) ? S_RESP : S_WR_CMD;
                    end
                end
                S_WR_CMD: state <= S_POLL;
                S_POLL: begin
                    polls_q <= polls_next;
                    if (bus.mmio_rdata[0]) begin
                        state <= S_SETTLE;
                    end else if (polls_next >= 32'(POLL_TIMEOUT)) begin
                        err_q <= 1'b1;
                        state <= S_TAIL;
                    end
                end
                S_SETTLE: state <= S_RD_SUM;
                S_RD_SUM: begin
                    if (sum_rd) sum_q <= 64'(bus.mmio_rdata);
                    state <= S_TAIL;
                end
`ifdef SATTN_HOST_PERF_EN
                S_PERF: begin
                    case (perf_idx)
                        2'd0:    gcyc_q <= 64'(bus.mmio_rdata);
                        2'd1:    mcyc_q <= 64'(bus.mmio_rdata);
                        default: dma_q  <= 64'(bus.mmio_rdata);
                    endcase
                    perf_idx <= perf_idx + 2'd1;
                    if (perf_idx == 2'd2) state <= S_RESP;
                end
`endif
                S_RESP: if (bus.rsp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.desc_ready = (state == S_IDLE);
    assign bus.idx_ready  = (state == S_WR_IDX) && idx_phase_b && bus.idx_valid;
    assign bus.mmio_wen   = bus_wen;
    assign bus.mmio_ren   = bus_ren;
    assign bus.mmio_addr  = ADDR_WIDTH'(bus_addr);
    assign bus.mmio_wdata = DATA_WIDTH'(bus_wdata);
    assign bus.rsp_valid  = (state == S_RESP);
    assign bus.rsp_sum    = sum_q;
    assign bus.rsp_err    = err_q;
    assign bus.rsp_polls  = polls_q;
`ifdef SATTN_HOST_PERF_EN
    assign bus.rsp_gcyc   = gcyc_q;
    assign bus.rsp_mcyc   = mcyc_q;
    assign bus.rsp_dma    = dma_q;
`endif
endmodule

// File: tb/tb_sattn_mmio_host.sv
// Directed bench for sattn_mmio_host: logs every bus cycle of a transaction and compares it against hand-built traces.
module tb_sattn_mmio_host;
    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [63:0] data;
    } ev_t;

    localparam logic [1:0] K_IDLE = 2'b00;
    localparam logic [1:0] K_WR   = 2'b01;
    localparam logic [1:0] K_RD   = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sattn_mmio_host_if #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) bus ();
    sattn_mmio_host_if #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) bus2 ();

    sattn_mmio_host #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .POLL_TIMEOUT(65535)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    sattn_mmio_host #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .POLL_TIMEOUT(8)) dut_to (
        .clk(clk), .rst(rst), .bus(bus2));

    int n_cmp = 0;
    int n_fail = 0;
    int done_after = 0;
    int poll_seen = 0;
    int idx_n = 0;
    int idx_ptr = 0;
    int stall_cycles = 0;
    int stall_left = 0;
    logic [15:0] idx_tab [4];
    logic [63:0] acc_sum = 64'h0;
    logic [63:0] sof_sum = 64'h0;
    logic [63:0] oth_sum = 64'h0;
    bit logging = 1'b0;
    ev_t log_q[$];
    ev_t exp_q[$];

    function automatic logic [63:0] base_val(input int i);
        return 64'hB000_0000_0000_0000 + 64'(i) * 64'h0101_0101_0101;
    endfunction

    function automatic logic [31:0] dim_val(input int j);
        return 32'hD000_0000 + 32'(j) * 32'h0011_0011;
    endfunction

    // Accelerator stand-in: DONE only on the chosen poll, noise in the upper poll bits.
    always_comb begin
        bus.mmio_rdata = 64'h0;
        if (bus.mmio_ren) begin
            case (bus.mmio_addr)
                16'h0060: bus.mmio_rdata = (done_after != 0 && poll_seen == done_after - 1)
                                           ? 64'hFFFF_0000_0000_0001 : 64'hFFFF_FFFF_FFFF_FFFE;
                16'h0068: bus.mmio_rdata = acc_sum;
                16'h0080: bus.mmio_rdata = sof_sum;
                16'h0088: bus.mmio_rdata = oth_sum;
                default:  bus.mmio_rdata = 64'h0;
            endcase
        end
        bus.idx_valid = (idx_ptr < idx_n) && (stall_left == 0);
        bus.idx_data  = idx_tab[idx_ptr[1:0]];
    end

    assign bus2.mmio_rdata = 64'h0;
    assign bus2.idx_valid  = 1'b0;
    assign bus2.idx_data   = 16'h0;

    always @(posedge clk) begin
        if (bus.desc_valid && bus.desc_ready) begin
            poll_seen  <= 0;
            idx_ptr    <= 0;
            stall_left <= 0;
        end else begin
            if (bus.mmio_ren && bus.mmio_addr == 16'h0060) poll_seen <= poll_seen + 1;
            if (bus.idx_ready) begin
                idx_ptr <= idx_ptr + 1;
                if (idx_ptr == 0) stall_left <= stall_cycles;
            end else if (stall_left > 0 && !bus.mmio_wen && !bus.mmio_ren) begin
                stall_left <= stall_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (logging && !bus.rsp_valid) begin
            e.kind = {bus.mmio_ren, bus.mmio_wen};
            e.addr = bus.mmio_addr;
            e.data = bus.mmio_ren ? 64'h0 : bus.mmio_wdata;
            log_q.push_back(e);
        end
    end

    function automatic void exp_push(input logic [1:0] k, input logic [15:0] a, input logic [63:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_regs();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_push(K_WR, 16'(8 * i), base_val(i));
        for (int j = 0; j < 6; j++) exp_push(K_WR, 16'(8'h30 + 8 * j), {32'h0, dim_val(j)});
    endfunction

    task automatic send_desc(input logic [7:0] cmd, input logic [15:0] cnt);
        log_q.delete();
        bus.desc_cmd     = cmd;
        bus.desc_idx_cnt = cnt;
        bus.desc_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.desc_valid = 1'b0;
        logging = 1'b1;
    endtask

    task automatic wait_rsp(output bit ok, input int limit);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        logging = 1'b0;
    endtask

    task automatic complete_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int activity;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.desc_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_desc_ready: got %b want 1", bus.desc_ready);
        end
        n_cmp++;
        if ({bus.mmio_wen, bus.mmio_ren, bus.idx_ready, bus.rsp_valid, bus.rsp_err} !== 5'b0) begin
            n_fail++; $display("[TB] FAIL reset_flags: got %b want 00000",
                               {bus.mmio_wen, bus.mmio_ren, bus.idx_ready, bus.rsp_valid, bus.rsp_err});
        end
        n_cmp++;
        if (bus.mmio_addr !== 16'h0 || bus.mmio_wdata !== 64'h0) begin
            n_fail++; $display("[TB] FAIL reset_bus: got addr=%h wdata=%h want 0/0", bus.mmio_addr, bus.mmio_wdata);
        end
        n_cmp++;
        if (bus.rsp_sum !== 64'h0 || bus.rsp_polls !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_rsp: got sum=%h polls=%0d want 0/0", bus.rsp_sum, bus.rsp_polls);
        end
        rst = 1'b0;
        activity = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mmio_wen || bus.mmio_ren || !bus.desc_ready) activity++;
        end
        n_cmp++;
        if (activity != 0) begin
            n_fail++; $display("[TB] FAIL idle_activity: got %0d active cycles want 0", activity);
        end
    endtask

    task automatic test_cmd14();
        bit ok;
        idx_tab[0] = 16'h0003; idx_tab[1] = 16'h0007; idx_n = 2; stall_cycles = 0;
        done_after = 20; acc_sum = 64'h1234;
        send_desc(8'h14, 16'd2);
        wait_rsp(ok, 200);
        n_cmp++;
        if (!ok) begin n_fail++; $display("[TB] FAIL cmd14_rsp: got no rsp_valid want rsp_valid"); end
        exp_regs();
        exp_push(K_WR, 16'h70, 64'd0); exp_push(K_WR, 16'h78, 64'd3);
        exp_push(K_WR, 16'h70, 64'd1); exp_push(K_WR, 16'h78, 64'd7);
        exp_push(K_WR, 16'h60, 64'h14);
        for (int i = 0; i < 20; i++) exp_push(K_RD, 16'h60, 64'h0);
        exp_push(K_IDLE, 16'h0, 64'h0);
        exp_push(K_RD, 16'h68, 64'h0);
        n_cmp++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++; $display("[TB] FAIL cmd14_len: got %0d cycles want %0d", log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (log_q[i] !== exp_q[i]) begin
                    n_fail++; $display("[TB] FAIL cmd14_trace[%0d]: got k=%b a=%h d=%h want k=%b a=%h d=%h", i,
                        log_q[i].kind, log_q[i].addr, log_q[i].data, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        n_cmp++;
        if (bus.rsp_sum !== 64'h1234 || bus.rsp_err !== 1'b0 || bus.rsp_polls !== 32'd20) begin
            n_fail++; $display("[TB] FAIL cmd14_result: got sum=%h err=%b polls=%0d want 1234/0/20",
                               bus.rsp_sum, bus.rsp_err, bus.rsp_polls);
        end
        complete_rsp();
        n_cmp++;
        if (bus.desc_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL cmd14_release: got ready=%b valid=%b want 1/0", bus.desc_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_cmd15_16();
        bit ok;
        idx_n = 0; done_after = 3; sof_sum = 64'hABCD;
        send_desc(8'h15, 16'd0);
        wait_rsp(ok, 100);
        n_cmp++;
        if (!ok || log_q.size() != 18) begin
            n_fail++; $display("[TB] FAIL cmd15_len: got ok=%b cycles=%0d want 1/18", ok, log_q.size());
        end else begin
            n_cmp++;
            if (log_q[17].kind !== K_RD || log_q[17].addr !== 16'h80 || log_q[16].kind !== K_IDLE) begin
                n_fail++; $display("[TB] FAIL cmd15_read: got k=%b a=%h settle=%b want 10/0080/00",
                                   log_q[17].kind, log_q[17].addr, log_q[16].kind);
            end
        end
        n_cmp++;
        if (bus.rsp_sum !== 64'hABCD || bus.rsp_polls !== 32'd3) begin
            n_fail++; $display("[TB] FAIL cmd15_result: got sum=%h polls=%0d want abcd/3", bus.rsp_sum, bus.rsp_polls);
        end
        complete_rsp();
        done_after = 1; oth_sum = 64'h0123_4567_89AB_CDEF;
        send_desc(8'h16, 16'd0);
        wait_rsp(ok, 100);
        n_cmp++;
        if (!ok || log_q.size() != 16) begin
            n_fail++; $display("[TB] FAIL cmd16_latency: got ok=%b cycles=%0d want 1/16", ok, log_q.size());
        end else begin
            n_cmp++;
            if (log_q[15].kind !== K_RD || log_q[15].addr !== 16'h88) begin
                n_fail++; $display("[TB] FAIL cmd16_read: got k=%b a=%h want 10/0088", log_q[15].kind, log_q[15].addr);
            end
        end
        n_cmp++;
        if (bus.rsp_sum !== 64'h0123_4567_89AB_CDEF || bus.rsp_polls !== 32'd1) begin
            n_fail++; $display("[TB] FAIL cmd16_result: got sum=%h polls=%0d want 0123456789abcdef/1",
                               bus.rsp_sum, bus.rsp_polls);
        end
        complete_rsp();
    endtask

    task automatic test_timeout();
        bit got;
        int polls;
        int others;
        got = 1'b0; polls = 0; others = 0;
        bus2.desc_cmd = 8'h14; bus2.desc_idx_cnt = 16'd0; bus2.desc_valid = 1'b1;
        @(posedge clk);
        #1;
        bus2.desc_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus2.rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (bus2.mmio_ren && bus2.mmio_addr == 16'h60) polls++;
            else if (bus2.mmio_ren) others++;
        end
        n_cmp++;
        if (!got || polls != 8 || others != 0) begin
            n_fail++; $display("[TB] FAIL timeout_polls: got rsp=%b polls=%0d other_reads=%0d want 1/8/0", got, polls, others);
        end
        n_cmp++;
        if (bus2.rsp_err !== 1'b1 || bus2.rsp_sum !== 64'h0 || bus2.rsp_polls !== 32'd8) begin
            n_fail++; $display("[TB] FAIL timeout_result: got err=%b sum=%h polls=%0d want 1/0/8",
                               bus2.rsp_err, bus2.rsp_sum, bus2.rsp_polls);
        end
        bus2.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus2.rsp_ready = 1'b0;
    endtask

    task automatic test_stall_backpressure();
        bit ok;
        int bad;
        idx_tab[0] = 16'h0003; idx_tab[1] = 16'h0007; idx_n = 2; stall_cycles = 3;
        done_after = 2; acc_sum = 64'h5A5A;
        send_desc(8'h14, 16'd2);
        wait_rsp(ok, 200);
        exp_regs();
        exp_push(K_WR, 16'h70, 64'd0); exp_push(K_WR, 16'h78, 64'd3); exp_push(K_WR, 16'h70, 64'd1);
        for (int i = 0; i < 3; i++) exp_push(K_IDLE, 16'h0, 64'h0);
        exp_push(K_WR, 16'h78, 64'd7); exp_push(K_WR, 16'h60, 64'h14);
        exp_push(K_RD, 16'h60, 64'h0); exp_push(K_RD, 16'h60, 64'h0);
        exp_push(K_IDLE, 16'h0, 64'h0); exp_push(K_RD, 16'h68, 64'h0);
        n_cmp++;
        if (!ok || log_q.size() != exp_q.size()) begin
            n_fail++; $display("[TB] FAIL stall_len: got ok=%b cycles=%0d want 1/%0d", ok, log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (log_q[i] !== exp_q[i]) begin
                    n_fail++; $display("[TB] FAIL stall_trace[%0d]: got k=%b a=%h d=%h want k=%b a=%h d=%h", i,
                        log_q[i].kind, log_q[i].addr, log_q[i].data, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.desc_ready !== 1'b0 || bus.rsp_sum !== 64'h5A5A ||
                bus.rsp_err !== 1'b0 || bus.rsp_polls !== 32'd2 || bus.mmio_wen || bus.mmio_ren) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("[TB] FAIL backpressure_hold: got %0d unstable cycles want 0", bad);
        end
        complete_rsp();
        n_cmp++;
        if (bus.desc_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL backpressure_release: got ready=%b valid=%b want 1/0", bus.desc_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_nop();
        bit ok;
        idx_tab[0] = 16'h00EE; idx_n = 1; stall_cycles = 0; done_after = 1;
        send_desc(8'h00, 16'd1);
        wait_rsp(ok, 100);
        exp_regs();
        exp_push(K_WR, 16'h70, 64'd0); exp_push(K_WR, 16'h78, 64'h00EE);
        n_cmp++;
        if (!ok || log_q.size() != exp_q.size()) begin
            n_fail++; $display("[TB] FAIL nop_len: got ok=%b cycles=%0d want 1/%0d", ok, log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (log_q[i] !== exp_q[i]) begin
                    n_fail++; $display("[TB] FAIL nop_trace[%0d]: got k=%b a=%h d=%h want k=%b a=%h d=%h", i,
                        log_q[i].kind, log_q[i].addr, log_q[i].data, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        n_cmp++;
        if (bus.rsp_sum !== 64'h0 || bus.rsp_err !== 1'b0 || bus.rsp_polls !== 32'd0) begin
            n_fail++; $display("[TB] FAIL nop_result: got sum=%h err=%b polls=%0d want 0/0/0",
                               bus.rsp_sum, bus.rsp_err, bus.rsp_polls);
        end
        complete_rsp();
    endtask

    task automatic test_reset_in_poll();
        bit found;
        int activity;
        idx_n = 0; done_after = 0; found = 1'b0;
        send_desc(8'h14, 16'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mmio_ren && bus.mmio_addr == 16'h60) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("[TB] FAIL rstpoll_reach: got no poll want poll"); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        logging = 1'b0;
        n_cmp++;
        if ({bus.mmio_wen, bus.mmio_ren, bus.rsp_valid, bus.idx_ready, bus.desc_ready} !== 5'b00001 ||
            bus.mmio_addr !== 16'h0) begin
            n_fail++; $display("[TB] FAIL rstpoll_outputs: got wen/ren/valid/iready/dready=%b addr=%h want 00001/0000",
                {bus.mmio_wen, bus.mmio_ren, bus.rsp_valid, bus.idx_ready, bus.desc_ready}, bus.mmio_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        activity = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.mmio_wen || bus.mmio_ren || bus.rsp_valid || !bus.desc_ready) activity++;
        end
        n_cmp++;
        if (activity != 0) begin
            n_fail++; $display("[TB] FAIL rstpoll_after: got %0d active cycles want 0", activity);
        end
    endtask

    initial begin
        bus.desc_valid = 1'b0; bus.rsp_ready = 1'b0; bus.desc_cmd = 8'h0; bus.desc_idx_cnt = 16'h0;
        bus2.desc_valid = 1'b0; bus2.rsp_ready = 1'b0; bus2.desc_cmd = 8'h0; bus2.desc_idx_cnt = 16'h0;
        bus2.desc_bases = '0; bus2.desc_dims = '0;
        for (int i = 0; i < 4; i++) idx_tab[i] = 16'h0;
        for (int i = 0; i < 6; i++) begin
            bus.desc_bases[64*i +: 64] = base_val(i);
            bus.desc_dims[32*i +: 32]  = dim_val(i);
        end
        test_reset();
        test_cmd14();
        test_cmd15_16();
        test_timeout();
        test_stall_backpressure();
        test_nop();
        test_reset_in_poll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
